console_writer: RTL and testbench
=================================

// Module: console_writer
// PURPOSE
//  Character-stream front end for the 80x30 text console: accepts bytes over a valid/ready handshake,
//  interprets control codes and writes glyph codes into the console text buffer write port.
//  Owns cursor state, line wrap, scrolling (block copy through the buffer) and screen clear.
//  Sits between the CPU/UART char source and the console text RAM (text_addr/text_write/text_in/text_out).
// PARAMETERS
//  COLS    80   characters per row
//  ROWS    30   rows per screen
//  ADDR_W  12   text buffer address width (COLS*ROWS <= 2**ADDR_W)
// PORTS
//  clock       in   1       system clock; all logic on posedge
//  reset       in   1       synchronous, active-high
//  char_valid  in   1       source has a byte on char_data
//  char_data   in   8       byte to print or control code
//  char_ready  out  1       block accepts char_data this cycle
//  text_addr   out  ADDR_W  text buffer address (read and write)
//  text_write  out  1       write strobe, one cycle per cell
//  text_in     out  8       write data to text buffer
//  text_rd     in   8       async read data from buffer at text_addr (console text_out)
//  cursor_x    out  7       current column 0..COLS-1
//  cursor_y    out  5       current row 0..ROWS-1
//  busy        out  1       clear or scroll in progress
// BEHAVIOUR
//  - All outputs registered. Reset: cursor 0/0, text_write 0, text_addr 0, text_in 0x20, char_ready 0,
//    busy 1, state CLEAR. Reset mid-operation aborts any scroll/write and restarts CLEAR.
//  - States: CLEAR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL.
//  - CLEAR: write 0x20 to addr 0..COLS*ROWS-1, one cell/cycle (2400 cycles); then cursor 0/0, IDLE.
//  - IDLE: char_ready=1. Transfer when char_valid&&char_ready; char latched, char_ready drops next cycle.
//  - 0x20..0x7E: WRITE next cycle: text_write=1, addr=cursor_y*COLS+cursor_x (shift-add, ADDR_W bits),
//    text_in=char; cursor_x+1. At cursor_x=COLS-1: cursor_x=0, cursor_y+1. Ready again cycle after WRITE.
//  - 0x0A LF: cursor_x=0, cursor_y+1. 0x0D CR: cursor_x=0, no write. 0x0C FF: enter CLEAR.
//  - 0x08 BS: if cursor_x>0 then cursor_x-1 and write 0x20 there; at cursor_x=0 no-op (no row wrap back).
//  - Any other byte: accepted and discarded, no write, cursor unchanged.
//  - Row overflow (cursor_y would become ROWS): cursor_y stays ROWS-1, enter scroll:
//    SCROLL_RD drives addr=i+COLS, captures text_rd; SCROLL_WR writes it to addr=i; i=0..COLS*(ROWS-1)-1
//    (2 cycles/cell), then FILL writes 0x20 to last row (COLS cycles), then IDLE. busy=1 throughout.
//  - Wrap-triggered scroll occurs after the char write, so the 80th char lands at col 79 of the old row.
//  - char_valid during busy/WRITE is ignored (ready low); source must hold data.
//  - text_write never asserted outside CLEAR/WRITE/SCROLL_WR/FILL; addr never exceeds COLS*ROWS-1.
// STRUCTURE
//  - console_defs.vh: COLS, ROWS, ADDR_W, CHR_SPACE, CHR_LF/CR/BS/FF, state encodings.
//  - Sub-module console_scroller: block copy (src=dst+COLS) and fill engine with start/done,
//    sharing the buffer port via a mux in console_writer; top keeps cursor FSM and handshake.
// TESTING
//  - Reset 1 cycle -> 2400 writes of 0x20 to addr 0..2399, char_ready=1 on cycle 2401, cursor 0/0.
//  - Send 0x41 at cursor 0/0 -> one write addr 0 data 0x41 next cycle; cursor 1/0; ready after 2 cycles.
//  - Send 80 printable chars on row 3 -> last write addr 319; cursor 0/4; 0x0D then 0x08 -> no writes.
//  - Fill row 1 with 'B', cursor 0/29, send 0x0A -> addrs 0..79 read back 'B', 2320..2399 = 0x20, cursor 0/29.
//  - Cursor 5/2, send 0x08 -> write addr 164 data 0x20, cursor 4/2; 0x07 -> accepted, no write.
//  - Assert reset mid-scroll -> no further scroll writes; CLEAR restarts at addr 0; cursor 0/0.

Source files
------------

// File: rtl/console_writer_pkg.sv
// ============================================================================
//  Module   : console_writer_pkg
//  Purpose  : Shared character codes, state encodings and cell-address helper
//             for the text console writer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package console_writer_pkg;

    localparam logic [7:0] c_CHR_SPACE = 8'h20;
    localparam logic [7:0] c_CHR_TILDE = 8'h7E;
    localparam logic [7:0] c_CHR_LF    = 8'h0A;
    localparam logic [7:0] c_CHR_CR    = 8'h0D;
    localparam logic [7:0] c_CHR_BS    = 8'h08;
    localparam logic [7:0] c_CHR_FF    = 8'h0C;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_SCROLL = 2'd3
    } writer_state_t;

    typedef enum logic [1:0] {
        SC_IDLE      = 2'd0,
        SC_SCROLL_RD = 2'd1,
        SC_SCROLL_WR = 2'd2,
        SC_FILL      = 2'd3
    } scroller_state_t;

    // y*cols + x built from shifted copies of y, one per set bit of cols
    function automatic logic [15:0] cell_addr(input logic [4:0] y, input logic [6:0] x,
                                              input int unsigned cols);
        logic [15:0] acc;
        acc = 16'(x);
        for (int b = 0; b < 8; b++) begin
            if (((cols >> b) & 32'd1) != 32'd0) begin
                acc = acc + (16'(y) << b);
            end
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/console_scroller.sv
// ============================================================================
//  Module   : console_scroller
//  Purpose  : Block-copy (src = dst + COLS) and space-fill engine driving the
//             text buffer port; requests are registered by the parent.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module console_scroller
    import console_writer_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_scroll,
    input  logic              i_start_clear,
    input  logic [7:0]        i_text_rd,
    output logic              o_req_write,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [7:0]        o_req_data,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] c_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_COPY = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] c_FILL_BASE = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] c_ROW_STEP  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    scroller_state_t   r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_idx_q, w_idx_d;

    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        o_req_write = 1'b0;
        o_req_addr  = r_idx_q;
        o_req_data  = c_CHR_SPACE;
        o_done      = 1'b0;

        case (r_state_q)
            SC_SCROLL_RD: begin
                o_req_addr = r_idx_q + c_ROW_STEP;
                w_state_d  = SC_SCROLL_WR;
            end
            // text_rd here reflects the source address registered last cycle
            SC_SCROLL_WR: begin
                o_req_write = 1'b1;
                o_req_data  = i_text_rd;
                if (r_idx_q == c_LAST_COPY) begin
                    w_state_d = SC_FILL;
                    w_idx_d   = c_FILL_BASE;
                end else begin
                    w_state_d = SC_SCROLL_RD;
                    w_idx_d   = r_idx_q + c_ONE;
                end
            end
            SC_FILL: begin
                o_req_write = 1'b1;
                if (r_idx_q == c_LAST_CELL) begin
                    o_done    = 1'b1;
                    w_state_d = SC_IDLE;
                    w_idx_d   = '0;
                end else begin
                    w_idx_d = r_idx_q + c_ONE;
                end
            end
            default: ;
        endcase

        if (i_start_clear) begin
            w_state_d = SC_FILL;
            w_idx_d   = '0;
        end else if (i_start_scroll) begin
            w_state_d = SC_SCROLL_RD;
            w_idx_d   = '0;
        end
    end

    // Reset lands directly in a whole-screen fill starting at cell 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= SC_FILL;
            r_idx_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/console_writer.sv
// ============================================================================
//  Module   : console_writer
//  Purpose  : Character-stream front end for the 80x30 text console: handshake,
//             control-code decode, cursor, wrap, scroll and clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module console_writer
    import console_writer_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic [ADDR_W-1:0] text_addr,
    output logic              text_write,
    output logic [7:0]        text_in,
    input  logic [7:0]        text_rd,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);

    writer_state_t     r_state_q, w_state_d;
    logic [6:0]        r_cur_x_q, w_cur_x_d;
    logic [4:0]        r_cur_y_q, w_cur_y_d;
    logic [ADDR_W-1:0] r_addr_q, w_addr_d;
    logic              r_write_q, w_write_d;
    logic [7:0]        r_data_q, w_data_d;
    logic              r_ready_q, w_ready_d;
    logic              r_busy_q, w_busy_d;
    logic              r_pend_q, w_pend_d;

    logic              w_start_scroll, w_start_clear, w_new_line;
    logic              w_req_write, w_done;
    logic [ADDR_W-1:0] w_req_addr;
    logic [7:0]        w_req_data;
    logic [ADDR_W-1:0] w_cell_addr, w_prev_addr;
    logic              w_accept;

    assign w_cell_addr = ADDR_W'(cell_addr(r_cur_y_q, r_cur_x_q, COLS));
    assign w_prev_addr = ADDR_W'(cell_addr(r_cur_y_q, r_cur_x_q - 7'd1, COLS));
    assign w_accept    = r_ready_q && char_valid;

    console_scroller #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_scroller (
        .clk            (clock),
        .rst            (reset),
        .i_start_scroll (w_start_scroll),
        .i_start_clear  (w_start_clear),
        .i_text_rd      (text_rd),
        .o_req_write    (w_req_write),
        .o_req_addr     (w_req_addr),
        .o_req_data     (w_req_data),
        .o_done         (w_done)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_cur_x_d      = r_cur_x_q;
        w_cur_y_d      = r_cur_y_q;
        w_addr_d       = r_addr_q;
        w_write_d      = 1'b0;
        w_data_d       = r_data_q;
        w_ready_d      = r_ready_q;
        w_busy_d       = r_busy_q;
        w_pend_d       = r_pend_q;
        w_start_scroll = 1'b0;
        w_start_clear  = 1'b0;
        w_new_line     = 1'b0;

        case (r_state_q)
            ST_CLEAR, ST_SCROLL: begin
                w_write_d = w_req_write;
                w_addr_d  = w_req_addr;
                w_data_d  = w_req_data;
                if (w_done) begin
                    w_state_d = ST_IDLE;
                    if (r_state_q == ST_CLEAR) begin
                        w_cur_x_d = 7'd0;
                        w_cur_y_d = 5'd0;
                    end
                end
            end
            ST_IDLE: begin
                w_ready_d = 1'b1;
                w_busy_d  = 1'b0;
                if (w_accept) begin
                    w_ready_d = 1'b0;
                    w_state_d = ST_WRITE;
                    if (char_data >= c_CHR_SPACE && char_data <= c_CHR_TILDE) begin
                        w_write_d = 1'b1;
                        w_addr_d  = w_cell_addr;
                        w_data_d  = char_data;
                        if (r_cur_x_q == c_LAST_COL) begin
                            w_cur_x_d  = 7'd0;
                            w_new_line = 1'b1;
                        end else begin
                            w_cur_x_d = r_cur_x_q + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            c_CHR_LF: begin
                                w_cur_x_d  = 7'd0;
                                w_new_line = 1'b1;
                            end
                            c_CHR_CR: w_cur_x_d = 7'd0;
                            c_CHR_BS: begin
                                if (r_cur_x_q != 7'd0) begin
                                    w_cur_x_d = r_cur_x_q - 7'd1;
                                    w_write_d = 1'b1;
                                    w_addr_d  = w_prev_addr;
                                    w_data_d  = c_CHR_SPACE;
                                end
                            end
                            c_CHR_FF: begin
                                w_state_d     = ST_CLEAR;
                                w_busy_d      = 1'b1;
                                w_start_clear = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    // Overflow past the last row is deferred until after the write
                    if (w_new_line) begin
                        if (r_cur_y_q == c_LAST_ROW) begin
                            w_pend_d = 1'b1;
                        end else begin
                            w_cur_y_d = r_cur_y_q + 5'd1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (r_pend_q) begin
                    w_state_d      = ST_SCROLL;
                    w_busy_d       = 1'b1;
                    w_pend_d       = 1'b0;
                    w_start_scroll = 1'b1;
                end else begin
                    w_state_d = ST_IDLE;
                    w_ready_d = 1'b1;
                end
            end
            default: w_state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ST_CLEAR;
            r_cur_x_q <= 7'd0;
            r_cur_y_q <= 5'd0;
            r_addr_q  <= '0;
            r_write_q <= 1'b0;
            r_data_q  <= c_CHR_SPACE;
            r_ready_q <= 1'b0;
            r_busy_q  <= 1'b1;
            r_pend_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cur_x_q <= w_cur_x_d;
            r_cur_y_q <= w_cur_y_d;
            r_addr_q  <= w_addr_d;
            r_write_q <= w_write_d;
            r_data_q  <= w_data_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
            r_pend_q  <= w_pend_d;
        end
    end

    assign char_ready = r_ready_q;
    assign text_addr  = r_addr_q;
    assign text_write = r_write_q;
    assign text_in    = r_data_q;
    assign cursor_x   = r_cur_x_q;
    assign cursor_y   = r_cur_y_q;
    assign busy       = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_console_writer.sv
// ============================================================================
//  Module   : tb_console_writer
//  Purpose  : Self-checking bench for console_writer against a screen-array
//             model of the console.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready, text_write, busy;
    logic [11:0] text_addr;
    logic [7:0]  text_in, text_rd;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    int n_checks = 0;
    int n_errors = 0;
    int oob      = 0;

    logic [7:0] ram [0:4095];
    logic [7:0] scr [0:CELLS-1];
    int         mx = 0;
    int         my = 0;
    int         wq_addr[$];
    int         wq_data[$];

    console_writer #(
        .COLS   (80),
        .ROWS   (30),
        .ADDR_W (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .text_addr  (text_addr),
        .text_write (text_write),
        .text_in    (text_in),
        .text_rd    (text_rd),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Text RAM: async read, write on the clock edge
    assign text_rd = ram[text_addr];

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] <= 8'hEE;
    end

    always @(posedge clock) begin
        if (text_write === 1'b1) begin
            ram[text_addr] <= text_in;
            wq_addr.push_back(int'(text_addr));
            wq_data.push_back(int'(text_in));
            if (text_addr >= 12'd2400) oob++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
        mx = 0;
        my = 0;
    endfunction

    function automatic void model_newline();
        if (my == ROWS - 1) begin
            for (int i = 0; i < CELLS - COLS; i++) scr[i] = scr[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) scr[i] = 8'h20;
        end else begin
            my++;
        end
    endfunction

    function automatic void model_put(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[my * COLS + mx] = c;
            mx++;
            if (mx == COLS) begin
                mx = 0;
                model_newline();
            end
        end else if (c == 8'h0A) begin
            mx = 0;
            model_newline();
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                scr[my * COLS + mx] = 8'h20;
            end
        end else if (c == 8'h0C) begin
            model_clear();
        end
    endfunction

    function automatic logic [7:0] rand_char();
        int r = int'($urandom_range(0, 99));
        if (r < 78) return 8'($urandom_range(32, 126));
        if (r < 86) return 8'h0A;
        if (r < 91) return 8'h0D;
        if (r < 96) return 8'h08;
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'h07;
            2:       return 8'h7F;
            default: return 8'($urandom_range(128, 255));
        endcase
    endfunction

    // ---------------- stimulus helpers (all enter and leave at negedge) ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        while (char_ready !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (char_ready !== 1'b1) check(tag, 0, 1);
    endtask

    task automatic send_char(input logic [7:0] c);
        char_data  = c;
        char_valid = ($urandom_range(0, 1) == 1);
        wait_ready("ready_timeout_pre");
        char_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        char_valid = 1'b0;
        char_data  = 8'($urandom);
        model_put(c);
        wait_ready("ready_timeout_post");
    endtask

    task automatic check_screen(input string tag);
        int bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== scr[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, int'(cursor_x), mx);
        check({tag, "_y"}, int'(cursor_y), my);
    endtask

    task automatic do_reset();
        int cyc = 0;
        int bad = 0;
        @(negedge clock);
        reset      = 1'b1;
        char_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_write", int'(text_write), 0);
        check("rst_ready", int'(char_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_text_in", int'(text_in), 'h20);
        check("rst_addr", int'(text_addr), 0);
        check("rst_cur_x", int'(cursor_x), 0);
        check("rst_cur_y", int'(cursor_y), 0);
        wq_addr.delete();
        wq_data.delete();
        while (char_ready !== 1'b1 && cyc < 3000) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        check("clear_cycles", cyc, 2401);
        check("clear_writes", wq_addr.size(), 2400);
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] != 'h20) bad++;
        check("clear_order", bad, 0);
        model_clear();
        check_screen("clear_screen");
        check_cursor("clear_cur");
    endtask

    initial begin
        int a;
        int bad;

        // Power-on clear
        do_reset();

        // Single printable char: write next cycle, ready two cycles after transfer
        wait_ready("ready_timeout_a");
        char_data  = 8'h41;
        char_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        char_valid = 1'b0;
        check("a_write", int'(text_write), 1);
        check("a_addr", int'(text_addr), 0);
        check("a_data", int'(text_in), 'h41);
        check("a_ready_low", int'(char_ready), 0);
        check("a_cur_x", int'(cursor_x), 1);
        check("a_cur_y", int'(cursor_y), 0);
        @(negedge clock);
        check("a_write_end", int'(text_write), 0);
        check("a_ready_back", int'(char_ready), 1);
        model_put(8'h41);

        // Backspace at 5/2, then an ignored control code
        send_char(8'h0A);
        send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h78);
        wq_addr.delete();
        wq_data.delete();
        send_char(8'h08);
        check("bs_writes", wq_addr.size(), 1);
        a = (wq_addr.size() > 0) ? wq_addr[0] : -1;
        check("bs_addr", a, 164);
        a = (wq_data.size() > 0) ? wq_data[0] : -1;
        check("bs_data", a, 'h20);
        check("bs_cur_x", int'(cursor_x), 4);
        check_cursor("bs_cur");
        wq_addr.delete();
        wq_data.delete();
        send_char(8'h07);
        check("bel_writes", wq_addr.size(), 0);
        check_cursor("bel_cur");

        // Full row 3 wraps to row 4; CR and BS at column 0 write nothing
        send_char(8'h0D);
        send_char(8'h0A);
        wq_addr.delete();
        wq_data.delete();
        for (int i = 0; i < COLS; i++) send_char(8'($urandom_range(32, 126)));
        check("row3_writes", wq_addr.size(), 80);
        a = (wq_addr.size() > 0) ? wq_addr[wq_addr.size() - 1] : -1;
        check("row3_last_addr", a, 319);
        check("row3_cur_x", int'(cursor_x), 0);
        check("row3_cur_y", int'(cursor_y), 4);
        wq_addr.delete();
        wq_data.delete();
        send_char(8'h0D);
        send_char(8'h08);
        check("cr_bs_writes", wq_addr.size(), 0);
        check_screen("row3_screen");

        // Form feed, row 1 of 'B', then scroll from the last row
        send_char(8'h0C);
        check_screen("ff_screen");
        check_cursor("ff_cur");
        send_char(8'h0A);
        for (int i = 0; i < COLS; i++) send_char(8'h42);
        for (int i = 0; i < 27; i++) send_char(8'h0A);
        check_cursor("pre_scroll_cur");
        wq_addr.delete();
        wq_data.delete();
        send_char(8'h0A);
        check("scroll_writes", wq_addr.size(), 2400);
        bad = 0;
        for (int i = 0; i < COLS; i++) if (ram[i] !== 8'h42) bad++;
        check("scroll_row0_b", bad, 0);
        bad = 0;
        for (int i = CELLS - COLS; i < CELLS; i++) if (ram[i] !== 8'h20) bad++;
        check("scroll_last_blank", bad, 0);
        check("scroll_cur_x", int'(cursor_x), 0);
        check("scroll_cur_y", int'(cursor_y), 29);
        check_screen("scroll_screen");

        // Random traffic from the top of a fresh screen
        send_char(8'h0C);
        for (int n = 0; n < 150; n++) begin
            send_char(rand_char());
            check_cursor("rand_cur");
        end
        check_screen("rand_screen");

        // Scroll of random content
        while (my < ROWS - 1) send_char(8'h0A);
        wq_addr.delete();
        wq_data.delete();
        send_char(8'h0A);
        check("rand_scroll_writes", wq_addr.size(), 2400);
        check_screen("rand_scroll_screen");
        check_cursor("rand_scroll_cur");

        // Reset in the middle of a scroll restarts the clear from cell 0
        char_data  = 8'h0A;
        char_valid = 1'b1;
        wait_ready("ready_timeout_mid");
        @(posedge clock);
        @(negedge clock);
        char_valid = 1'b0;
        repeat (301) @(negedge clock);
        check("mid_busy", int'(busy), 1);
        do_reset();

        check("addr_range", oob, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
